// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit: latency-padded multiplier and radix-2
// restoring divider behind a single-op valid/ready handshake with kill.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);
  localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int MCNT = (MUL_LAT >= 2) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_a, r_b, r_rem, r_rd;
  logic            r_neg_q, r_neg_r;

  // operand decode at accept
  logic            w_accept, w_is_div, w_sgn, w_s1, w_s2, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_rd;
  assign w_accept  = in_valid & (r_state == S_IDLE) & ~kill;
  assign w_is_div  = funct3[2];
  assign w_sgn     = ~funct3[0];
  assign w_s1      = w_sgn & rs1[XLEN-1];
  assign w_s2      = w_sgn & rs2[XLEN-1];
  assign w_div0    = (rs2 == '0);
  assign w_ovf     = w_sgn & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  assign w_special = w_is_div & (w_div0 | w_ovf);
  assign w_spec_rd = funct3[1] ? (w_div0 ? rs1 : '0) : (w_div0 ? '1 : rs1);

  // multiplier reads the live inputs only when MUL_LAT==1 retires at accept
  logic [XLEN-1:0]   w_ma, w_mb, w_mul_rd;
  logic [2:0]        w_mf3;
  logic [2*XLEN-1:0] w_ea, w_eb, w_prod;
  assign w_ma     = (r_state == S_IDLE) ? rs1 : r_a;
  assign w_mb     = (r_state == S_IDLE) ? rs2 : r_b;
  assign w_mf3    = (r_state == S_IDLE) ? funct3 : r_f3;
  assign w_ea     = {{XLEN{(w_mf3[1:0] != 2'b11) & w_ma[XLEN-1]}}, w_ma};
  assign w_eb     = {{XLEN{(w_mf3[1] == 1'b0) & w_mb[XLEN-1]}}, w_mb};
  assign w_prod   = w_ea * w_eb;
  assign w_mul_rd = (w_mf3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // one restoring step; r_a shifts dividend out and quotient in
  logic [XLEN:0]   w_sh, w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_n, w_quo_n, w_div_rd;
  assign w_sh     = {r_rem, r_a[XLEN-1]};
  assign w_sub    = w_sh - {1'b0, r_b};
  assign w_ge     = ~w_sub[XLEN];
  assign w_rem_n  = w_ge ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
  assign w_quo_n  = {r_a[XLEN-2:0], w_ge};
  assign w_div_rd = r_f3[1] ? (r_neg_r ? -w_rem_n : w_rem_n)
                            : (r_neg_q ? -w_quo_n : w_quo_n);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_special)         w_next = S_DONE;
        else if (w_is_div)     w_next = S_DIV;
        else if (MUL_LAT == 1) w_next = S_DONE;
        else                   w_next = S_MUL;
      end
      S_MUL:  if (r_cnt == '0) w_next = S_DONE;
      S_DIV:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (out_ready)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_rd    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3    <= funct3;
        r_neg_q <= w_s1 ^ w_s2;
        r_neg_r <= w_s1;
        r_rem   <= '0;
        r_a     <= (w_is_div & w_s1) ? -rs1 : rs1;
        r_b     <= (w_is_div & w_s2) ? -rs2 : rs2;
        r_cnt   <= w_is_div ? CW'(XLEN - 1) : CW'(MCNT);
        if (w_special)                        r_rd <= w_spec_rd;
        else if (!w_is_div && MUL_LAT == 1)   r_rd <= w_mul_rd;
      end else if (!kill) begin
        case (r_state)
          S_MUL: begin
            if (r_cnt == '0) r_rd <= w_mul_rd;
            else             r_cnt <= r_cnt - 1'b1;
          end
          S_DIV: begin
            r_a   <= w_quo_n;
            r_rem <= w_rem_n;
            if (r_cnt == '0) r_rd <= w_div_rd;
            else             r_cnt <= r_cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign rd        = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare.
module tb_muldiv_unit;
  logic        clk = 0, rst_n = 0, in_valid = 0, kill = 0, out_ready = 1;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic        in_ready, out_valid, busy;
  logic [31:0] rd;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .busy(busy));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint    sp;
    logic [63:0] up;
    int        sa, sb;
    logic [31:0] q, r;
    case (f3)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      default: begin
        sa = a; sb = b;
        if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
        else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
        else if (!f3[0]) begin q = sa / sb; r = sa % sb; end
        else begin q = a / b; r = a % b; end
        return f3[1] ? r : q;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // model: cycle-level transaction tracker
  logic        m_inflight = 0, m_valid = 0, m_hold_ok = 1;
  logic [31:0] m_rd = 0;
  int          m_due = 0, lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0; m_valid = 0; m_rd = 0; m_hold_ok = 1;
    end else begin
      cyc++;
      if (kill) begin
        if (m_inflight) m_hold_ok = 0;
        m_inflight = 0; m_valid = 0;
      end else if (m_valid) begin
        if (out_ready) begin m_valid = 0; m_inflight = 0; m_hold_ok = 1; end
      end else if (m_inflight) begin
        if (cyc == m_due) m_valid = 1;
      end else if (in_valid) begin
        m_rd = ref_op(funct3, rs1, rs2);
        lat  = ref_lat(funct3, rs1, rs2);
        m_inflight = 1;
        if (lat == 1) m_valid = 1;
        else m_due = cyc + lat - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("busy", {31'b0, busy}, {31'b0, m_inflight});
    if (rst_n) chk("in_ready", {31'b0, in_ready}, {31'b0, !m_inflight});
    if (m_valid || (!m_inflight && m_hold_ok)) chk("rd", rd, m_rd);
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy want idle (cycle %0d)", cyc);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    wait_idle();
    funct3 = f3; rs1 = a; rs2 = b; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rd", rd, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1;

    chk("pin_mul", ref_op(0, 4, 6), 32'd24);
    chk("pin_mul_neg", ref_op(0, -2, -4), 32'd8);
    chk("pin_mulhu", ref_op(3, 32'hFFFF_FFFE, 32'hFFFF_FFFC), 32'hFFFF_FFFA);
    chk("pin_mulhsu", ref_op(2, -2, 32'hFFFF_FFFC), 32'hFFFF_FFFE);
    chk("pin_mulh", ref_op(1, -2, -4), 32'h0);
    chk("pin_div", ref_op(4, -8, 2), -32'd4);
    chk("pin_rem", ref_op(6, -10, 3), -32'd1);
    chk("pin_divu", ref_op(5, 32'hFFFF_FFF0, 3), 32'h5555_5550);
    chk("pin_remu", ref_op(7, 32'hFFFF_FFF6, 3), 32'h0);
    chk("pin_div0", ref_op(4, 7, 0), 32'hFFFF_FFFF);
    chk("pin_rem0", ref_op(6, 7, 0), 32'd7);
    chk("pin_ovf_div", ref_op(4, 32'h8000_0000, -1), 32'h8000_0000);
    chk("pin_ovf_rem", ref_op(6, 32'h8000_0000, -1), 32'h0);
    chk("pin_lat_mul", ref_lat(0, 4, 6), 2);
    chk("pin_lat_div", ref_lat(4, -8, 2), 33);
    chk("pin_lat_spec", ref_lat(4, 7, 0), 1);

    issue(0, 4, 6);         issue(0, -2, -4);
    issue(3, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    issue(2, -2, 32'hFFFF_FFFC); issue(1, -2, -4);
    issue(4, -8, 2);        issue(6, -10, 3);
    issue(5, 32'hFFFF_FFF0, 3); issue(7, 32'hFFFF_FFF6, 3);
    issue(4, 7, 0);         issue(6, 7, 0);
    issue(4, 32'h8000_0000, -1); issue(6, 32'h8000_0000, -1);
    wait_idle();

    out_ready = 0;
    issue(0, 4, 6);
    repeat (6) @(negedge clk);
    out_ready = 1;
    wait_idle();

    issue(4, 100, 7);
    repeat (9) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    wait_idle();

    funct3 = 0; rs1 = 3; rs2 = 3; in_valid = 1; kill = 1;
    @(negedge clk);
    in_valid = 0; kill = 0;

    issue(4, -8, 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_rd", rd, 32'h0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      funct3    = 3'($urandom);
      rs1       = pick();
      rs2       = pick();
      out_ready = ($urandom % 4) != 0;
      kill      = ($urandom % 150) == 0;
    end
    @(negedge clk);
    in_valid = 0; kill = 0; out_ready = 1;
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
